div_unit: RTL and testbench

//   Multi-cycle signed 32-bit divider; produces the HI (remainder) and LO (quotient) values

---
 rtl/div_pkg.sv | 15 +
 rtl/div_if.sv | 27 ++
 rtl/div_step.sv | 23 ++
 rtl/div_unit.sv | 117 +++++++++++
 tb/tb_div_unit.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle signed divider.
package div_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the control FSM (master) and the divider (slave).
interface div_if
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);

    logic              start;
    logic [DATA_W-1:0] dividend;
    logic [DATA_W-1:0] divisor;
    logic              busy;
    logic              done;
    logic              div0;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div0, hi, lo
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {R,Q}, trial subtract, restore.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // Partial remainder stays below |B| <= 2^(DATA_W-1), so the kept value always fits DATA_W bits.
    assign shifted = {rem_i, quo_i[DATA_W-1]};
    assign trial   = shifted - {1'b0, dvs_i};
    assign rem_o   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    assign quo_o   = {quo_i[DATA_W-2:0], ~trial[DATA_W]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: lo = quotient, hi = remainder (sign follows dividend).
// Optional DIV_ZERO_CHECK_EN: a zero divisor short-circuits to DONE with div0 set.
module div_unit
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic clk,
    input  logic reset,
    div_if.slave bus
);

    localparam int               CNT_W    = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    // IDLE wait start | PREP take magnitudes | CALC DATA_W steps | FIX apply signs | DONE pulse
    div_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              sa_q, sb_q;
    logic [DATA_W-1:0] rem_q, quo_q, bmag_q;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic              busy_q, done_q, div0_q;

    logic [DATA_W-1:0] rem_d, quo_d;
    logic              div_by_zero;

`ifdef DIV_ZERO_CHECK_EN
    assign div_by_zero = (bus.divisor == '0);
`else
    assign div_by_zero = 1'b0;
`endif

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (bmag_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            bmag_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (div_by_zero) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            div0_q  <= 1'b1;
                        end else begin
                            a_q     <= bus.dividend;
                            b_q     <= bus.divisor;
                            sa_q    <= bus.dividend[DATA_W-1];
                            sb_q    <= bus.divisor[DATA_W-1];
                            state_q <= PREP;
                        end
                    end
                end
                PREP: begin
                    rem_q   <= '0;
                    quo_q   <= a_q[DATA_W-1] ? -a_q : a_q;
                    bmag_q  <= b_q[DATA_W-1] ? -b_q : b_q;
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q    <= (sa_q ^ sb_q) ? -quo_q : quo_q;
                    hi_q    <= sa_q ? -rem_q : rem_q;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized operands vs. an arithmetic model.
module tb_div_unit;

    localparam int LAT_FULL = 35;   // edges counted from the start-sampling edge up to done visible

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] mdl_lo;
    logic [31:0] mdl_hi;

    div_if #(.DATA_W(32)) bus();

    div_unit #(.DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating signed division on wide integers; zero divisor follows the magnitude rules.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] lo, output logic [31:0] hi,
                         output logic d0, output int lat);
        longint la, lb, q, r;
        la = $signed(a);
        lb = $signed(b);
        if (b == 32'd0) begin
`ifdef DIV_ZERO_CHECK_EN
            lo  = mdl_lo;
            hi  = mdl_hi;
            d0  = 1'b1;
            lat = 1;
`else
            lo  = a[31] ? 32'd1 : 32'hFFFF_FFFF;
            hi  = a;
            d0  = 1'b0;
            lat = LAT_FULL;
`endif
        end else begin
            q   = la / lb;
            r   = la % lb;
            lo  = q[31:0];
            hi  = r[31:0];
            d0  = 1'b0;
            lat = LAT_FULL;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] lo, output logic [31:0] hi,
                          output logic d0, output logic busy_e0, output int edges);
        wait_idle();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_e0   = bus.busy;
        edges     = 1;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        lo = bus.lo;
        hi = bus.hi;
        d0 = bus.div0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b div0=%b hi=%h lo=%h, need all zero",
                     bus.busy, bus.done, bus.div0, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset  = 1'b0;
        mdl_lo = '0;
        mdl_hi = '0;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb [5] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] el [5] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] eh [5] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'd0};
        logic [31:0] lo, hi;
        logic d0, b0;
        int edges;
        for (int i = 0; i < 5; i++) begin
            do_div(va[i], vb[i], lo, hi, d0, b0, edges);
            checks++;
            if (lo !== el[i] || hi !== eh[i]) begin
                errors++;
                $display("FAIL directed_%0d result: lo=%h hi=%h, need lo=%h hi=%h", i, lo, hi, el[i], eh[i]);
            end
            checks++;
            if (edges !== LAT_FULL || b0 !== 1'b1 || d0 !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d timing: edges=%0d busy_e0=%b div0=%b, need %0d 1 0",
                         i, edges, b0, d0, LAT_FULL);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL directed_%0d done_pulse: done=%b one edge later, need 0", i, bus.done);
            end
            mdl_lo = el[i];
            mdl_hi = eh[i];
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] va [2] = '{32'd7, 32'hFFFF_FFF9};
        logic [31:0] lo, hi, elo, ehi;
        logic d0, b0, ed0;
        int edges, elat;
        for (int i = 0; i < 2; i++) begin
`ifdef DIV_ZERO_CHECK_EN
            elo = mdl_lo;
            ehi = mdl_hi;
            ed0 = 1'b1;
            elat = 1;
`else
            elo = (i == 0) ? 32'hFFFF_FFFF : 32'd1;
            ehi = va[i];
            ed0 = 1'b0;
            elat = LAT_FULL;
`endif
            do_div(va[i], 32'd0, lo, hi, d0, b0, edges);
            checks++;
            if (lo !== elo || hi !== ehi || d0 !== ed0 || edges !== elat) begin
                errors++;
                $display("FAIL div_zero_%0d: lo=%h hi=%h div0=%b edges=%0d, need lo=%h hi=%h div0=%b edges=%0d",
                         i, lo, hi, d0, edges, elo, ehi, ed0, elat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus.div0 !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL div_zero_%0d flag_clear: div0=%b done=%b, need 0 0", i, bus.div0, bus.done);
            end
            mdl_lo = elo;
            mdl_hi = ehi;
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, lo, hi, elo, ehi;
        logic d0, b0, ed0;
        int edges, elat;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = -($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            model(a, b, elo, ehi, ed0, elat);
            do_div(a, b, lo, hi, d0, b0, edges);
            checks++;
            if (lo !== elo || hi !== ehi || d0 !== ed0 || edges !== elat) begin
                errors++;
                $display("FAIL random_%0d %h/%h: lo=%h hi=%h div0=%b edges=%0d, need lo=%h hi=%h div0=%b edges=%0d",
                         i, a, b, lo, hi, d0, edges, elo, ehi, ed0, elat);
            end
            mdl_lo = elo;
            mdl_hi = ehi;
        end
    endtask

    task automatic test_start_ignored();
        int  edges;
        int  late_done;
        wait_idle();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        edges     = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (bus.lo !== mdl_lo || bus.hi !== mdl_hi) begin
            errors++;
            $display("FAIL hold_in_calc: lo=%h hi=%h, need lo=%h hi=%h", bus.lo, bus.hi, mdl_lo, mdl_hi);
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd555;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        edges++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checks++;
        if (bus.lo !== 32'd14 || bus.hi !== 32'd2 || edges !== LAT_FULL) begin
            errors++;
            $display("FAIL start_ignored: lo=%h hi=%h edges=%0d, need lo=0000000e hi=00000002 edges=%0d",
                     bus.lo, bus.hi, edges, LAT_FULL);
        end
        late_done = 0;
        repeat (45) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) late_done++;
        end
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL start_not_queued: %0d cycles busy/done after first result, need 0", late_done);
        end
        mdl_lo = 32'd14;
        mdl_hi = 32'd2;
    endtask

    task automatic test_reset_mid();
        logic [31:0] lo, hi;
        logic d0, b0;
        int edges;
        wait_idle();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_calc: busy=%b done=%b hi=%h lo=%h, need 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clk);
        reset  = 1'b0;
        mdl_lo = '0;
        mdl_hi = '0;
        do_div(32'd20, 32'd3, lo, hi, d0, b0, edges);
        checks++;
        if (lo !== 32'd6 || hi !== 32'd2 || edges !== LAT_FULL) begin
            errors++;
            $display("FAIL after_reset 20/3: lo=%h hi=%h edges=%0d, need lo=00000006 hi=00000002 edges=%0d",
                     lo, hi, edges, LAT_FULL);
        end
        mdl_lo = 32'd6;
        mdl_hi = 32'd2;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mdl_lo = '0;
        mdl_hi = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
